// File: rtl/hs4_rx_bridge.sv
// Bridge from a 4-phase asynchronous micropipeline into a clocked FWFT FIFO.
// req_i is synchronized; ack_o is withheld while the FIFO is full to stall upstream.
module hs4_rx_bridge #(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_i,
  input  logic [DATA_W-1:0]        data_i,
  output logic                     ack_o,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {IDLE, ACKED} state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   req_s;
  state_t                 state_q, state_d;
  logic                   ack_q, ack_d;
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic                   full, push, pop;
  logic [DATA_W-1:0]      mem [DEPTH];

  // Only the first stage ever samples the asynchronous req_i.
  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        always_ff @(posedge clk or posedge rst) begin
          if (rst) sync_q[0] <= 1'b0;
          else     sync_q[0] <= req_i;
        end
      end else begin : g_rest
        always_ff @(posedge clk or posedge rst) begin
          if (rst) sync_q[gi] <= 1'b0;
          else     sync_q[gi] <= sync_q[gi-1];
        end
      end
    end
  endgenerate

  assign req_s = sync_q[SYNC_STAGES-1];
  assign full  = (count_q == CW'(DEPTH));
  assign pop   = (count_q != '0) && out_ready;

  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    push    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_s && !full) begin
          push    = 1'b1;
          ack_d   = 1'b1;
          state_d = ACKED;
        end
      end
      ACKED: begin
        if (!req_s) begin
          ack_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        ack_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      ack_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      ack_q    <= ack_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset so it can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= data_i;
  end

  assign ack_o     = ack_q;
  assign count_o   = count_q;
  assign out_valid = (count_q != '0);
  assign out_data  = mem[rd_ptr_q];

endmodule

// File: tb/tb_hs4_rx_bridge.sv
// Directed and randomized checks of the 4-phase receive bridge (DEPTH=4, SYNC_STAGES=2).
module tb_hs4_rx_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_i;
  logic [31:0] data_i;
  logic        ack_o;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [2:0]  count_o;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] got[$];
  logic [31:0] exp_q[$];
  bit          mon_en = 1'b0;
  int          max_cnt = 0;

  hs4_rx_bridge #(.DATA_W(32), .DEPTH(4), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .data_i(data_i), .ack_o(ack_o),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .count_o(count_o)
  );

  always #5 clk = ~clk;

  // Records every word that leaves the FIFO, sampled mid-cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      if (out_valid && out_ready) got.push_back(out_data);
      if (int'(count_o) > max_cnt) max_cnt = int'(count_o);
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic xfer(input logic [31:0] d, output bit ok);
    int n;
    ok = 1'b1;
    data_i = d;
    req_i  = 1'b1;
    n = 0;
    while (ack_o !== 1'b1 && n < 100) begin step(1); n++; end
    if (ack_o !== 1'b1) ok = 1'b0;
    req_i = 1'b0;
    n = 0;
    while (ack_o !== 1'b0 && n < 100) begin step(1); n++; end
    if (ack_o !== 1'b0) ok = 1'b0;
  endtask

  task automatic test_reset;
    n_cmp++;
    if (ack_o !== 1'b0 || count_o !== 3'd0 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state: ack=%b count=%0d valid=%b, need 0/0/0", ack_o, count_o, out_valid);
    end
    $display("test_reset: ack=%b count=%0d valid=%b", ack_o, count_o, out_valid);
  endtask

  task automatic test_single;
    data_i = 32'hDEADBEEF;
    req_i  = 1'b1;
    step(2);
    n_cmp++;
    if (ack_o !== 1'b0) begin
      n_bad++; $display("FAIL single_ack_early: ack=%b after 2 edges, need 0", ack_o);
    end
    step(1);
    n_cmp++;
    if (ack_o !== 1'b1 || out_valid !== 1'b1 || out_data !== 32'hDEADBEEF || count_o !== 3'd1) begin
      n_bad++;
      $display("FAIL single_capture: ack=%b valid=%b data=%h count=%0d, need 1/1/deadbeef/1",
               ack_o, out_valid, out_data, count_o);
    end
    req_i = 1'b0;
    step(2);
    n_cmp++;
    if (ack_o !== 1'b1) begin
      n_bad++; $display("FAIL single_ack_hold: ack=%b 2 edges after req fall, need 1", ack_o);
    end
    step(1);
    n_cmp++;
    if (ack_o !== 1'b0) begin
      n_bad++; $display("FAIL single_ack_fall: ack=%b 3 edges after req fall, need 0", ack_o);
    end
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || count_o !== 3'd0) begin
      n_bad++; $display("FAIL single_pop: valid=%b count=%0d, need 0/0", out_valid, count_o);
    end
    $display("test_single: transfer of deadbeef done");
  endtask

  task automatic test_fill;
    bit ok;
    out_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      xfer(32'(k), ok);
      n_cmp++;
      if (!ok) begin n_bad++; $display("FAIL fill_xfer_timeout: word %0d, need handshake", k); end
    end
    n_cmp++;
    if (count_o !== 3'd4) begin n_bad++; $display("FAIL fill_count: count=%0d, need 4", count_o); end
    data_i = 32'd5;
    req_i  = 1'b1;
    step(10);
    n_cmp++;
    if (ack_o !== 1'b0 || count_o !== 3'd4) begin
      n_bad++; $display("FAIL fill_backpressure: ack=%b count=%0d, need 0/4", ack_o, count_o);
    end
    out_ready = 1'b1;
    n_cmp++;
    if (out_data !== 32'd1) begin n_bad++; $display("FAIL fill_head: data=%0d, need 1", out_data); end
    step(1);
    out_ready = 1'b0;
    n_cmp++;
    if (ack_o !== 1'b0 || count_o !== 3'd3) begin
      n_bad++; $display("FAIL fill_no_same_edge_push: ack=%b count=%0d, need 0/3", ack_o, count_o);
    end
    step(1);
    n_cmp++;
    if (ack_o !== 1'b1 || count_o !== 3'd4) begin
      n_bad++; $display("FAIL fill_fifth_capture: ack=%b count=%0d, need 1/4", ack_o, count_o);
    end
    req_i = 1'b0;
    step(3);
    out_ready = 1'b1;
    for (int k = 2; k <= 5; k++) begin
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== 32'(k)) begin
        n_bad++; $display("FAIL fill_order: valid=%b data=%0d, need 1/%0d", out_valid, out_data, k);
      end
      step(1);
    end
    out_ready = 1'b0;
    n_cmp++;
    if (count_o !== 3'd0) begin n_bad++; $display("FAIL fill_drain: count=%0d, need 0", count_o); end
    $display("test_fill: fill, backpressure and drain done");
  endtask

  task automatic test_back_to_back;
    bit ok;
    xfer(32'd10, ok);
    xfer(32'd11, ok);
    n_cmp++;
    if (!ok || count_o !== 3'd2) begin
      n_bad++; $display("FAIL b2b_setup: ok=%b count=%0d, need 1/2", ok, count_o);
    end
    data_i = 32'd12;
    req_i  = 1'b1;
    step(2);
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
    n_cmp++;
    if (ack_o !== 1'b1 || count_o !== 3'd2 || out_data !== 32'd11) begin
      n_bad++;
      $display("FAIL b2b_push_pop: ack=%b count=%0d head=%0d, need 1/2/11", ack_o, count_o, out_data);
    end
    req_i = 1'b0;
    step(3);
    out_ready = 1'b1;
    for (int k = 11; k <= 12; k++) begin
      n_cmp++;
      if (out_data !== 32'(k)) begin n_bad++; $display("FAIL b2b_order: data=%0d, need %0d", out_data, k); end
      step(1);
    end
    out_ready = 1'b0;
    $display("test_back_to_back: push+pop at count 2 done");
  endtask

  task automatic test_wrap;
    bit ok;
    bit all_ok = 1'b1;
    got.delete();
    max_cnt = 0;
    out_ready = 1'b1;
    mon_en = 1'b1;
    for (int k = 0; k < 10; k++) begin
      xfer(32'(k), ok);
      all_ok &= ok;
    end
    step(2);
    mon_en = 1'b0;
    out_ready = 1'b0;
    n_cmp++;
    if (!all_ok || got.size() != 10 || max_cnt > 1) begin
      n_bad++;
      $display("FAIL wrap_stream: ok=%b words=%0d maxcnt=%0d, need 1/10/<=1", all_ok, got.size(), max_cnt);
    end
    for (int k = 0; k < got.size(); k++) begin
      n_cmp++;
      if (got[k] !== 32'(k)) begin n_bad++; $display("FAIL wrap_order: word %0d=%0d, need %0d", k, got[k], k); end
    end
    $display("test_wrap: %0d words streamed", got.size());
  endtask

  task automatic test_reset_mid;
    bit ok;
    int n;
    xfer(32'd20, ok);
    xfer(32'd21, ok);
    data_i = 32'd22;
    req_i  = 1'b1;
    n = 0;
    while (ack_o !== 1'b1 && n < 100) begin step(1); n++; end
    n_cmp++;
    if (ack_o !== 1'b1 || count_o !== 3'd3) begin
      n_bad++; $display("FAIL rstmid_setup: ack=%b count=%0d, need 1/3", ack_o, count_o);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (ack_o !== 1'b0 || count_o !== 3'd0 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL rstmid_async: ack=%b count=%0d valid=%b, need 0/0/0", ack_o, count_o, out_valid);
    end
    step(2);
    rst = 1'b0;
    n = 0;
    while (ack_o !== 1'b1 && n < 100) begin step(1); n++; end
    n_cmp++;
    if (ack_o !== 1'b1 || count_o !== 3'd1 || out_data !== 32'd22) begin
      n_bad++;
      $display("FAIL rstmid_recapture: ack=%b count=%0d data=%0d, need 1/1/22", ack_o, count_o, out_data);
    end
    req_i = 1'b0;
    step(3);
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
    $display("test_reset_mid: reset during ACKED done");
  endtask

  task automatic test_random;
    bit prod_done = 1'b0;
    bit all_ok = 1'b1;
    int cyc = 0;
    got.delete();
    exp_q.delete();
    mon_en = 1'b1;
    fork
      begin
        bit ok;
        logic [31:0] d;
        for (int k = 0; k < 1000; k++) begin
          d = $urandom;
          exp_q.push_back(d);
          step($urandom_range(0, 3));
          xfer(d, ok);
          all_ok &= ok;
        end
        prod_done = 1'b1;
      end
      begin
        while (!(prod_done && count_o == 3'd0) && cyc < 60000) begin
          out_ready = ($urandom_range(0, 2) != 0);
          step(1);
          cyc++;
        end
        out_ready = 1'b0;
      end
    join
    step(1);
    mon_en = 1'b0;
    n_cmp++;
    if (!all_ok || got.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL random_count: ok=%b got=%0d words, need 1/%0d", all_ok, got.size(), exp_q.size());
    end
    for (int k = 0; k < got.size() && k < exp_q.size(); k++) begin
      n_cmp++;
      if (got[k] !== exp_q[k]) begin
        n_bad++; $display("FAIL random_word: idx %0d got %h, need %h", k, got[k], exp_q[k]);
      end
    end
    $display("test_random: %0d words checked", got.size());
  endtask

  initial begin
    rst = 1'b1;
    req_i = 1'b0;
    data_i = '0;
    out_ready = 1'b0;
    step(3);
    test_reset;
    rst = 1'b0;
    step(2);
    test_single;
    test_fill;
    test_back_to_back;
    test_wrap;
    test_reset_mid;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
